// File: rtl/upc_seg7_if.sv
// Bus between the UPC checker and its driver: code/mark in, flags and six HEX digit drives out.
interface upc_seg7_if;
    logic [2:0] upc;
    logic       mark;
    logic       discounted;
    logic       stolen;
    logic [6:0] leds1, leds2, leds3, leds4, leds5, leds6;

    modport master (
        output upc, mark,
        input  discounted, stolen, leds1, leds2, leds3, leds4, leds5, leds6
    );
    modport slave (
        input  upc, mark,
        output discounted, stolen, leds1, leds2, leds3, leds4, leds5, leds6
    );
endinterface

// File: rtl/upc_seg7.sv
// Registered UPC checker: decodes code/mark into sale/stolen flags and a left-justified
// item name on six active-low 7-segment digits, all through one output register stage.
module upc_seg7 (
    input  logic        clk,
    input  logic        reset,
    upc_seg7_if.slave   bus
);
    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] G_S   = 7'h12, G_H = 7'h09, G_O = 7'h40, G_E = 7'h06;
    localparam logic [6:0] G_A   = 7'h08, G_T = 7'h07, G_C = 7'h46, G_B = 7'h03;
    localparam logic [6:0] G_L   = 7'h47, G_R = 7'h2F, G_F = 7'h0E, G_G = 7'h42;
    localparam logic [6:0] G_BLK = 7'h7F;

    typedef struct packed {
        logic                discounted;
        logic                stolen;
        logic [5:0][6:0]     digits;   // [5] = leds6 (HEX5) ... [0] = leds1 (HEX0)
    } out_t;

    localparam out_t OUT_RST = '{discounted: 1'b0, stolen: 1'b0, digits: {6{G_BLK}}};

    out_t out_d, out_q;
    logic expensive;

    always_comb begin
        out_d     = OUT_RST;
        expensive = 1'b0;
        unique case (bus.upc)
            3'b000: begin expensive = 1'b1; out_d.digits = {G_S, G_H, G_O, G_E, G_BLK, G_BLK}; end
            3'b001: begin out_d.discounted = 1'b1; out_d.digits = {G_H, G_A, G_T, G_BLK, G_BLK, G_BLK}; end
            3'b011: begin
                out_d.discounted = 1'b1;
                expensive        = 1'b1;
                out_d.digits     = {G_C, G_O, G_A, G_T, G_BLK, G_BLK};
            end
            3'b100: out_d.digits = {G_B, G_E, G_L, G_T, G_BLK, G_BLK};
            3'b101: begin
                out_d.discounted = 1'b1;
                expensive        = 1'b1;
                out_d.digits     = {G_S, G_C, G_A, G_R, G_F, G_BLK};
            end
            3'b110: begin expensive = 1'b1; out_d.digits = {G_B, G_A, G_G, G_BLK, G_BLK, G_BLK}; end
            default: ;  // unused codes 010/111 stay blank and unflagged
        endcase
        out_d.stolen = expensive & ~bus.mark;
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= OUT_RST;
        else       out_q <= out_d;
    end

    assign bus.discounted = out_q.discounted;
    assign bus.stolen     = out_q.stolen;
    assign bus.leds6      = out_q.digits[5];
    assign bus.leds5      = out_q.digits[4];
    assign bus.leds4      = out_q.digits[3];
    assign bus.leds3      = out_q.digits[2];
    assign bus.leds2      = out_q.digits[1];
    assign bus.leds1      = out_q.digits[0];
endmodule

// File: tb/tb_upc_seg7.sv
// Scoreboard bench for upc_seg7: expected outputs queued at drive time, checked one edge later.
module tb_upc_seg7;
    logic clk = 1'b0;
    logic reset;
    upc_seg7_if bus ();

    upc_seg7 dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [1:0]  flags;   // {discounted, stolen}
        logic [41:0] disp;    // {leds6..leds1}
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] u, input logic m, input logic r, input string tag);
        exp_t e;
        logic dis, expv;
        e.tag = tag;
        dis   = 1'b0;
        expv  = 1'b0;
        e.disp = {6{7'h7F}};
        case (u)
            3'd0: begin expv = 1; e.disp = {7'h12, 7'h09, 7'h40, 7'h06, 7'h7F, 7'h7F}; end
            3'd1: begin dis = 1;  e.disp = {7'h09, 7'h08, 7'h07, 7'h7F, 7'h7F, 7'h7F}; end
            3'd3: begin dis = 1; expv = 1; e.disp = {7'h46, 7'h40, 7'h08, 7'h07, 7'h7F, 7'h7F}; end
            3'd4: e.disp = {7'h03, 7'h06, 7'h47, 7'h07, 7'h7F, 7'h7F};
            3'd5: begin dis = 1; expv = 1; e.disp = {7'h12, 7'h46, 7'h08, 7'h2F, 7'h0E, 7'h7F}; end
            3'd6: begin expv = 1; e.disp = {7'h03, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F}; end
            default: ;
        endcase
        e.flags = {dis, expv & ~m};
        if (r) begin
            e.flags = 2'b00;
            e.disp  = {6{7'h7F}};
        end
        return e;
    endfunction

    // Drive on the falling edge, queue the expectation, check just after the next rising edge.
    task automatic step(input logic [2:0] u, input logic m, input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        bus.upc  = u;
        bus.mark = m;
        reset    = r;
        sb.push_back(model(u, m, r, tag));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_flags"}, {62'd0, bus.discounted, bus.stolen}, {62'd0, e.flags});
            chk({e.tag, "_disp"},
                {22'd0, bus.leds6, bus.leds5, bus.leds4, bus.leds3, bus.leds2, bus.leds1},
                {22'd0, e.disp});
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.upc  = 3'd0;
        bus.mark = 1'b0;

        step(3'd0, 1'b0, 1'b1, "rst0");
        step(3'd0, 1'b0, 1'b1, "rst1");
        step(3'd0, 1'b0, 1'b0, "rel_shoe");

        for (int i = 0; i < 16; i++)
            step(i[3:1], i[0], 1'b0, $sformatf("sweep%0d", i));

        step(3'd5, 1'b0, 1'b0, "scarf_m0");
        step(3'd5, 1'b1, 1'b0, "scarf_m1");
        step(3'd5, 1'b0, 1'b0, "scarf_m0b");

        step(3'd1, 1'b0, 1'b0, "hat");
        step(3'd4, 1'b0, 1'b0, "belt");

        step(3'd2, 1'b0, 1'b0, "un2_m0");
        step(3'd2, 1'b1, 1'b0, "un2_m1");
        step(3'd7, 1'b0, 1'b0, "un7_m0");
        step(3'd7, 1'b1, 1'b0, "un7_m1");

        step(3'd6, 1'b0, 1'b0, "bag");
        step(3'd6, 1'b0, 1'b1, "mid_rst");
        step(3'd6, 1'b0, 1'b0, "bag_back");
        step(3'd3, 1'b0, 1'b1, "rst_coat");
        step(3'd3, 1'b0, 1'b0, "coat");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
